// File: rtl/bram_pkg.sv
// Shared state encoding and word geometry for the BRAM port master.
// INIT exists only when BRAM_PORT_MASTER_INIT_EN is defined.
package bram_pkg;

   localparam int WORD_BYTES = 4;
   localparam int BE_W       = 4;

   typedef enum logic [1:0] {
      IDLE,
      RD_CAP,
      RSP
`ifdef BRAM_PORT_MASTER_INIT_EN
      , INIT
`endif
   } state_t;

endpackage

// File: rtl/bram_port_master.sv
// Single-outstanding BRAM port master; write/error response at T+1, read response at T+2 after accept.
// Backpressure: req_ready only in IDLE, response held until the rsp_ready handshake.
// BRAM_PORT_MASTER_INIT_EN adds a post-reset clear of every word (init_busy for DEPTH cycles).
module bram_port_master
   import bram_pkg::*;
#(
   parameter int DEPTH = 12,
   parameter int AW    = 12
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [BE_W-1:0] req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [31:0]     req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_rdata,
   output logic            rsp_err,
   output logic            init_busy,
   output logic            EN,
   output logic [BE_W-1:0] WE,
   output logic [31:0]     Di,
   output logic [AW-1:0]   A,
   input  logic [31:0]     Do
);

   localparam int            LANE_SH   = $clog2(WORD_BYTES);
   localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
   localparam logic [AW-1:0] LANE_MASK = AW'(WORD_BYTES - 1);

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] req_idx;
   logic [AW-1:0] req_word;
   logic          in_range;

   assign req_idx   = req_addr >> LANE_SH;
   assign req_word  = req_addr & ~LANE_MASK;
   assign in_range  = (req_idx < DEPTH_A);
   assign req_ready = (state == IDLE);

`ifdef BRAM_PORT_MASTER_INIT_EN
   localparam int CW = $clog2(DEPTH + 1);
   logic [CW-1:0] init_cnt;
   assign init_busy = (state == INIT);
`else
   assign init_busy = 1'b0;
`endif

   // Port drive is masked during reset so a stray accept can never write the BRAM.
   always_comb begin
      EN = 1'b0;
      WE = '0;
      Di = '0;
      A  = '0;
      if (!RST) begin
         case (state)
            IDLE: begin
               if (req_valid && in_range) begin
                  EN = 1'b1;
                  WE = req_we;
                  Di = req_wdata;
                  A  = req_word;
               end
            end
            RD_CAP: begin
               EN = 1'b1;
               A  = addr_q;
            end
`ifdef BRAM_PORT_MASTER_INIT_EN
            INIT: begin
               EN = 1'b1;
               WE = '1;
               A  = AW'(init_cnt) << LANE_SH;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
`ifdef BRAM_PORT_MASTER_INIT_EN
         state    <= INIT;
         init_cnt <= '0;
`else
         state    <= IDLE;
`endif
         addr_q    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q    <= req_word;
                  rsp_rdata <= '0;
                  rsp_err   <= !in_range;
                  if (!in_range || (req_we != '0)) begin
                     rsp_valid <= 1'b1;
                     state     <= RSP;
                  end else begin
                     state     <= RD_CAP;
                  end
               end
            end
            RD_CAP: begin
               rsp_rdata <= Do;
               rsp_valid <= 1'b1;
               state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
`ifdef BRAM_PORT_MASTER_INIT_EN
            INIT: begin
               init_cnt <= init_cnt + CW'(1);
               if (init_cnt == CW'(DEPTH - 1))
                  state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/bram_port_master.md
BRAM_PORT_MASTER -- requirements
Module: bram_port_master

Interface
REQ-001 Parameter DEPTH, default 12, words in the attached BRAM.
REQ-002 Parameter AW, default 12, byte-address width of A and req_addr.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-007 req_we  input  4  byte write enables; 4'h0 means read.
REQ-008 req_addr  input  AW  byte address; bits [1:0] ignored.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  request address out of range.
REQ-014 init_busy  output  1  init sequencer active.
REQ-015 EN, WE[3:0], Di[31:0], A[AW-1:0]  output  BRAM port drive; Do[31:0] input, BRAM read data.

Function
REQ-016 States: INIT, IDLE, RD_CAP, RSP; req_ready = (state==IDLE).
REQ-017 Word index = req_addr>>2; in range iff index < DEPTH; A = index<<2 (A[1:0]=0).
REQ-018 Accept cycle T, in range: EN=1, WE=req_we, Di=req_wdata, A driven combinationally in T.
REQ-019 Out-of-range accept: EN=0, no BRAM access, go to RSP with rsp_err=1, rsp_rdata=0.
REQ-020 In-range write: go to RSP, rsp_err=0, rsp_rdata=0; rsp_valid high from T+1.
REQ-021 In-range read: go to RD_CAP; in T+1 EN=1, WE=4'h0, A held; capture Do at end of T+1; rsp_valid high from T+2.
REQ-022 RSP holds rsp_valid, rsp_rdata and rsp_err stable until the rsp_ready handshake, then returns to IDLE; the next accept occurs in the following cycle at the earliest.
REQ-023 Outside accept, RD_CAP and INIT: EN=0, WE=0, Di=0, A=0.
REQ-024 Exactly one response per accepted request, in order; no response without a request.

Reset
REQ-025 With RST high at a posedge: state goes to IDLE (INIT if enabled); rsp_valid=0, rsp_rdata=0, rsp_err=0, init counter=0.
REQ-026 Reset mid-read or mid-response discards the pending response; no BRAM write occurs in the reset cycle.

Configuration
REQ-027 Macro BRAM_PORT_MASTER_INIT_EN defined: after reset, INIT writes 0 to words 0..DEPTH-1, one per cycle (EN=1, WE=4'hF, Di=0, A=cnt<<2); init_busy=1 and req_ready=0 for exactly DEPTH cycles, then IDLE.
REQ-028 Macro undefined: no INIT state or counter; reset goes to IDLE; init_busy tied 0.

Structure
REQ-029 Shared package bram_pkg holds the state enum, the word-size constant (4 bytes) and the byte-enable width.
REQ-030 No sub-module; the BRAM is instantiated only in the bench.

Verification
REQ-031 Write req_addr=0x008, req_we=4'hF, req_wdata=0xDEADBEEF, then read 0x008 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-032 Write 0xFFFFFFFF to 0x004, then req_we=4'h2 with wdata=0x00001200, then read -> 0xFFFF12FF.
REQ-033 Read req_addr=0x030 (index 12) -> rsp_err=1, rsp_rdata=0, EN never asserted.
REQ-034 Read with rsp_ready held low for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout, one handshake only.
REQ-035 RST asserted in the RD_CAP cycle -> rsp_valid=0 next cycle, no response is delivered, and a following request works normally.
REQ-036 With BRAM_PORT_MASTER_INIT_EN, after reset read all 12 words -> all 0; init_busy is high for exactly 12 cycles.
